tlv5618_rx_model: RTL and testbench

- Synthesizable responder for the TLV5618 3-wire serial DAC interface: the receiving end of the frames our DAC driver emits.
- Oversamples CS_N/SCLK/DIN on the 50 MHz system clock, deserializes 16-bit words MSB first, decodes R1/SPD/PWR/R0 and maintains shadow DAC A, DAC B and BUFFER registers exactly as the device does.
- Used in on-chip loopback self-test and as the checker in driver benches.

---
 rtl/tlv5618_rx_model.sv | 171 +++++++++++++++++
 tb/tb_tlv5618_rx_model.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tlv5618_rx_model.sv
// Receiving end of the TLV5618 3-wire serial DAC link. Inputs are oversampled on clk,
// 16-bit frames are deserialized, and the DAC A/B/BUFFER shadow registers are updated.
`timescale 1ns/1ps
module tlv5618_rx_model #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dac_cs_n,
    input  logic        dac_sclk,
    input  logic        dac_din,
    output logic [11:0] dac_a_code,
    output logic [11:0] dac_b_code,
    output logic [11:0] buffer_code,
    output logic        spd,
    output logic        pwr,
    output logic [15:0] frame_word,
    output logic        frame_valid,
    output logic        reserved_cmd,
    output logic        frame_error,
    output logic        busy
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ARMED, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync_p0, sclk_sync_p0, din_sync_p0;
    logic                   cs_hist_p1, sclk_hist_p1;
    logic [SYNC_STAGES:0]   flush;
    logic                   cs_s, sclk_s, din_s, inputs_ready;
    logic                   cs_fall, cs_rise, sclk_fall, sclk_rise;

    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_BITS-1:0]  sr;
    logic                   over_flag;

    logic start, shift_en, commit, abort, overrun;
    logic r1, r0;

    // Synchronizer chains plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_p0   <= '1;
            sclk_sync_p0 <= '1;
            din_sync_p0  <= '0;
            cs_hist_p1   <= 1'b1;
            sclk_hist_p1 <= 1'b1;
            flush        <= '0;
        end else begin
            cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], dac_cs_n};
            sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], dac_sclk};
            din_sync_p0  <= {din_sync_p0[SYNC_STAGES-2:0], dac_din};
            cs_hist_p1   <= cs_s;
            sclk_hist_p1 <= sclk_s;
            flush        <= {flush[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s   = cs_sync_p0[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_p0[SYNC_STAGES-1];
    assign din_s  = din_sync_p0[SYNC_STAGES-1];

    // Edges are trusted only once both compared samples come from real input, so a
    // CS_N already low at reset release never looks like a fresh frame start.
    assign inputs_ready = flush[SYNC_STAGES];
    assign cs_fall   = inputs_ready &  cs_hist_p1 & ~cs_s;
    assign cs_rise   = inputs_ready & ~cs_hist_p1 &  cs_s;
    assign sclk_fall = inputs_ready & ~cs_s &  sclk_hist_p1 & ~sclk_s;
    assign sclk_rise = inputs_ready & ~cs_s & ~sclk_hist_p1 &  sclk_s;

    assign busy = ~cs_s;
    assign r1   = sr[FRAME_BITS-1];
    assign r0   = sr[FRAME_BITS-4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        overrun   = 1'b0;
        if (cs_fall) begin
            state_nxt = SHIFT;
            start     = 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (cs_rise) begin
                        abort     = 1'b1;
                        state_nxt = IDLE;
                    end else if (sclk_fall) begin
                        shift_en = 1'b1;
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    // A simultaneous SCLK rise and CS rise still commits only once
                    if (cs_rise || sclk_rise) begin
                        commit    = 1'b1;
                        state_nxt = cs_rise ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (cs_rise)                      state_nxt = IDLE;
                    else if (sclk_fall && !over_flag) overrun   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Deserializer and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            sr           <= '0;
            over_flag    <= 1'b0;
            dac_a_code   <= '0;
            dac_b_code   <= '0;
            buffer_code  <= '0;
            spd          <= 1'b0;
            pwr          <= 1'b0;
            frame_word   <= '0;
            frame_valid  <= 1'b0;
            reserved_cmd <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            frame_valid  <= commit;
            reserved_cmd <= commit & r1 & r0;
            frame_error  <= abort | overrun;
            if (start) begin
                bit_cnt   <= '0;
                sr        <= '0;
                over_flag <= 1'b0;
            end else if (shift_en) begin
                sr      <= {sr[FRAME_BITS-2:0], din_s};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (overrun) over_flag <= 1'b1;
            if (commit) begin
                frame_word <= sr;
                if (!(r1 && r0)) begin
                    spd <= sr[FRAME_BITS-2];
                    pwr <= sr[FRAME_BITS-3];
                end
                case ({r1, r0})
                    2'b00: begin
                        dac_b_code  <= sr[11:0];
                        buffer_code <= sr[11:0];
                    end
                    2'b01: buffer_code <= sr[11:0];
                    2'b10: begin
                        dac_a_code <= sr[11:0];
                        dac_b_code <= buffer_code;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tlv5618_rx_model.sv
// Directed frames into tlv5618_rx_model; expected events are queued by the driver and
// matched against frame_valid/frame_error pulses by an independent monitor.
`timescale 1ns/1ps
module tb_tlv5618_rx_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dac_cs_n, dac_sclk, dac_din;
    logic [11:0] dac_a_code, dac_b_code, buffer_code;
    logic        spd, pwr;
    logic [15:0] frame_word;
    logic        frame_valid, reserved_cmd, frame_error, busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_err;
        logic [15:0] word;
        logic        rsv;
        logic [11:0] a, b, bf;
        logic        s, p;
    } exp_t;

    exp_t exp_q[$];

    always #10 clk = ~clk;

    tlv5618_rx_model #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din),
        .dac_a_code(dac_a_code), .dac_b_code(dac_b_code), .buffer_code(buffer_code),
        .spd(spd), .pwr(pwr), .frame_word(frame_word),
        .frame_valid(frame_valid), .reserved_cmd(reserved_cmd),
        .frame_error(frame_error), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic push_commit(input logic [15:0] w, input logic rsv, input logic [11:0] a,
                               input logic [11:0] b, input logic [11:0] bf,
                               input logic s, input logic p);
        exp_t e;
        e.is_err = 1'b0; e.word = w; e.rsv = rsv;
        e.a = a; e.b = b; e.bf = bf; e.s = s; e.p = p;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [11:0] a, input logic [11:0] b, input logic [11:0] bf,
                            input logic s, input logic p);
        exp_t e;
        e.is_err = 1'b1; e.word = '0; e.rsv = 1'b0;
        e.a = a; e.b = b; e.bf = bf; e.s = s; e.p = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [15:0] w, input int nfall);
        for (int i = 0; i < nfall; i++) begin
            dac_din = (i < 16) ? w[15 - i] : 1'b0;
            wait_clk(4);
            dac_sclk = 1'b0;
            wait_clk(4);
            dac_sclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int nfall);
        dac_cs_n = 1'b0;
        wait_clk(4);
        shift_bits(w, nfall);
        wait_clk(4);
        dac_cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},     32'(dac_a_code),   32'h0);
        check({tag, "_b"},     32'(dac_b_code),   32'h0);
        check({tag, "_buf"},   32'(buffer_code),  32'h0);
        check({tag, "_spd"},   32'(spd),          32'h0);
        check({tag, "_pwr"},   32'(pwr),          32'h0);
        check({tag, "_word"},  32'(frame_word),   32'h0);
        check({tag, "_pulse"}, 32'({frame_valid, reserved_cmd, frame_error}), 32'h0);
        check({tag, "_busy"},  32'(busy),         32'h0);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_error || reserved_cmd)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({frame_valid, reserved_cmd, frame_error}), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    check("err_pulse", 32'({frame_valid, reserved_cmd, frame_error}), 32'h1);
                end else begin
                    check("commit_pulse", 32'({frame_valid, frame_error}), 32'h2);
                    check("frame_word",   32'(frame_word),   32'(e.word));
                    check("reserved_cmd", 32'(reserved_cmd), 32'(e.rsv));
                end
                check("dac_a",  32'(dac_a_code),  32'(e.a));
                check("dac_b",  32'(dac_b_code),  32'(e.b));
                check("buffer", 32'(buffer_code), 32'(e.bf));
                check("spd",    32'(spd),         32'(e.s));
                check("pwr",    32'(pwr),         32'(e.p));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        dac_cs_n = 1'b1;
        dac_sclk = 1'b1;
        dac_din  = 1'b0;
        wait_clk(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        wait_clk(6);

        // 00: DAC B and BUFFER loaded, SPD=1
        push_commit(16'h4ABC, 1'b0, 12'h000, 12'hABC, 12'hABC, 1'b1, 1'b0);
        send_frame(16'h4ABC, 16);

        // 01: BUFFER only; then 10: DAC A from data, DAC B from old BUFFER
        push_commit(16'h1123, 1'b0, 12'h000, 12'hABC, 12'h123, 1'b0, 1'b0);
        send_frame(16'h1123, 16);
        push_commit(16'h8456, 1'b0, 12'h456, 12'h123, 12'h123, 1'b0, 1'b0);
        send_frame(16'h8456, 16);

        // 9xxx has R1=1, R0=1: reserved, nothing else moves
        push_commit(16'h97FF, 1'b1, 12'h456, 12'h123, 12'h123, 1'b0, 1'b0);
        send_frame(16'h97FF, 16);

        // Cxxx decodes as R1=1, SPD=1, R0=0: DAC A load with transfer
        push_commit(16'hC7FF, 1'b0, 12'h7FF, 12'h123, 12'h123, 1'b1, 1'b0);
        send_frame(16'hC7FF, 16);

        // Short frame aborts without changing anything
        push_err(12'h7FF, 12'h123, 12'h123, 1'b1, 1'b0);
        send_frame(16'hFFFF, 9);
        push_commit(16'h0FFF, 1'b0, 12'h7FF, 12'hFFF, 12'hFFF, 1'b0, 1'b0);
        send_frame(16'h0FFF, 16);

        // Overlong frame: one commit, then exactly one error
        push_commit(16'h2001, 1'b0, 12'h7FF, 12'h001, 12'h001, 1'b0, 1'b1);
        push_err(12'h7FF, 12'h001, 12'h001, 1'b0, 1'b1);
        send_frame(16'h2001, 18);

        // Reset mid-frame clears everything asynchronously
        dac_cs_n = 1'b0;
        wait_clk(4);
        shift_bits(16'h0555, 8);
        wait_clk(2);
        #5;
        rst_n = 1'b0;
        #2;
        check_all_zero("async_rst");
        dac_cs_n = 1'b1;
        dac_sclk = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        push_commit(16'h0555, 1'b0, 12'h000, 12'h555, 12'h555, 1'b0, 1'b0);
        send_frame(16'h0555, 16);

        wait_clk(20);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
